// File: rtl/fixed_float_pipe.sv
// ============================================================================
//  Module      : fixed_float_pipe
//  Description : Pipelined signed fixed-point <-> IEEE-754 single converter
//                with valid/ready backpressure, RNE rounding and saturation.
//  Revision    : 1.0 - initial pipelined release
// ============================================================================
`default_nettype none

module fixed_float_pipe #(
  parameter int FIX_W = 32,
  parameter int POS_W = 5,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             opcode,
  input  logic [31:0]      targetnumber,
  input  logic [POS_W-1:0] fixpointpos,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      result,
  output logic [TAG_W-1:0] out_tag,
  output logic             flag_inexact,
  output logic             flag_overflow,
  output logic             flag_invalid
);

  localparam logic [31:0]        c_fix_w   = 32'(FIX_W);
  localparam logic [4:0]         c_pos_max = 5'(FIX_W - 1);
  localparam logic signed [9:0]  c_top     = 10'(FIX_W - 1);
  localparam logic [31:0]        c_min_mag = 32'd1 << (FIX_W - 1);

  logic w_advance;
  assign w_advance = !out_valid || out_ready;
  assign in_ready  = w_advance;

  // ---------------- operand capture ----------------
  logic [31:0] w_pos_ext;
  logic [4:0]  w_pos_clamped;
  assign w_pos_ext     = 32'(fixpointpos);
  assign w_pos_clamped = (w_pos_ext >= c_fix_w) ? c_pos_max : w_pos_ext[4:0];

  logic             r_v0, r_op0;
  logic [31:0]      r_num0;
  logic [4:0]       r_pos0;
  logic [TAG_W-1:0] r_tag0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_v0   <= 1'b0;
      r_op0  <= 1'b0;
      r_num0 <= '0;
      r_pos0 <= '0;
      r_tag0 <= '0;
    end else if (w_advance) begin
      r_v0   <= in_valid;
      r_op0  <= opcode;
      r_num0 <= targetnumber;
      r_pos0 <= w_pos_clamped;
      r_tag0 <= in_tag;
    end
  end

  // ---------------- stage 1: sign/magnitude or float decode ----------------
  logic [FIX_W-1:0] w_fix, w_mag;
  logic             w_fix_neg;
  assign w_fix     = r_num0[FIX_W-1:0];
  assign w_fix_neg = w_fix[FIX_W-1];
  // The most negative value negates onto itself, which is the correct unsigned magnitude.
  assign w_mag     = w_fix_neg ? -w_fix : w_fix;

  logic             r_v1, r_op1, r_sign1;
  logic [4:0]       r_pos1;
  logic [TAG_W-1:0] r_tag1;
  logic [31:0]      r_mag1;
  logic [7:0]       r_exp1;
  logic [23:0]      r_sig1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_v1    <= 1'b0;
      r_op1   <= 1'b0;
      r_sign1 <= 1'b0;
      r_pos1  <= '0;
      r_tag1  <= '0;
      r_mag1  <= '0;
      r_exp1  <= '0;
      r_sig1  <= '0;
    end else if (w_advance) begin
      r_v1    <= r_v0;
      r_op1   <= r_op0;
      r_sign1 <= r_op0 ? r_num0[31] : w_fix_neg;
      r_pos1  <= r_pos0;
      r_tag1  <= r_tag0;
      r_mag1  <= 32'(w_mag);
      r_exp1  <= r_num0[30:23];
      r_sig1  <= {(r_num0[30:23] != 8'd0), r_num0[22:0]};
    end
  end

  // ---------------- stage 2: leading-one align / significand shift ----------------
  logic [4:0]  w_p;
  logic        w_nz;
  logic [31:0] w_al;
  logic [7:0]  w_fexp;

  always_comb begin
    w_p = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (r_mag1[i]) w_p = 5'(i);
    end
  end

  assign w_nz   = |r_mag1;
  assign w_al   = r_mag1 << (5'd31 - w_p);
  assign w_fexp = 8'd127 + {3'd0, w_p} - {3'd0, r_pos1};

  logic signed [9:0] w_shift;
  logic [54:0]       w_t;
  logic [31:0]       w_imag;
  logic              w_ix, w_nan, w_ovf;

  assign w_shift = $signed({2'b00, r_exp1}) - 10'sd127 + $signed({5'd0, r_pos1});
  assign w_t     = {31'd0, r_sig1} << w_shift[4:0];

  always_comb begin
    w_imag = '0;
    w_ix   = 1'b0;
    w_nan  = 1'b0;
    w_ovf  = 1'b0;
    if (r_exp1 == 8'hFF) begin
      if (r_sig1[22:0] != 23'd0) w_nan = 1'b1;
      else                       w_ovf = 1'b1;
    end else if (r_exp1 == 8'd0) begin
      w_ix = |r_sig1[22:0];
    end else if (w_shift < 10'sd0) begin
      w_ix = 1'b1;
    end else if (w_shift < c_top) begin
      w_imag = w_t[54:23];
      w_ix   = |w_t[22:0];
    end else if (w_shift == c_top && r_sig1[22:0] == 23'd0 && r_sign1) begin
      // Exactly the most negative representable value: no saturation needed.
      w_imag = c_min_mag;
    end else begin
      w_ovf = 1'b1;
    end
  end

  logic             r_v2, r_op2, r_sign2, r_zero2, r_ix2, r_nan2, r_ovf2;
  logic [TAG_W-1:0] r_tag2;
  logic [31:0]      r_val2;
  logic [7:0]       r_fexp2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_v2    <= 1'b0;
      r_op2   <= 1'b0;
      r_sign2 <= 1'b0;
      r_zero2 <= 1'b0;
      r_ix2   <= 1'b0;
      r_nan2  <= 1'b0;
      r_ovf2  <= 1'b0;
      r_tag2  <= '0;
      r_val2  <= '0;
      r_fexp2 <= '0;
    end else if (w_advance) begin
      r_v2    <= r_v1;
      r_op2   <= r_op1;
      r_sign2 <= r_sign1;
      r_zero2 <= !w_nz;
      r_ix2   <= w_ix;
      r_nan2  <= w_nan;
      r_ovf2  <= w_ovf;
      r_tag2  <= r_tag1;
      r_val2  <= r_op1 ? w_imag : w_al;
      r_fexp2 <= w_fexp;
    end
  end

  // ---------------- stage 3: rounding, packing, saturation ----------------
  logic [22:0] w_mant;
  logic        w_guard, w_sticky, w_rup;
  logic [23:0] w_mant_r;
  logic [7:0]  w_exp_r;
  logic [31:0] w_float;

  assign w_mant   = r_val2[30:8];
  assign w_guard  = r_val2[7];
  assign w_sticky = |r_val2[6:0];
  assign w_rup    = w_guard && (w_sticky || w_mant[0]);
  assign w_mant_r = {1'b0, w_mant} + {23'd0, w_rup};
  assign w_exp_r  = r_fexp2 + {7'd0, w_mant_r[23]};
  assign w_float  = r_zero2 ? 32'd0 : {r_sign2, w_exp_r, w_mant_r[22:0]};

  logic [FIX_W-1:0] w_sfix, w_sat, w_fres;
  logic [31:0]      w_fres32;

  assign w_sfix = r_sign2 ? -r_val2[FIX_W-1:0] : r_val2[FIX_W-1:0];
  assign w_sat  = r_sign2 ? {1'b1, {(FIX_W-1){1'b0}}} : {1'b0, {(FIX_W-1){1'b1}}};
  assign w_fres = r_nan2 ? '0 : (r_ovf2 ? w_sat : w_sfix);

  generate
    if (FIX_W < 32) begin : g_sext
      assign w_fres32 = {{(32-FIX_W){w_fres[FIX_W-1]}}, w_fres};
    end else begin : g_full
      assign w_fres32 = w_fres;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid     <= 1'b0;
      result        <= '0;
      out_tag       <= '0;
      flag_inexact  <= 1'b0;
      flag_overflow <= 1'b0;
      flag_invalid  <= 1'b0;
    end else if (w_advance) begin
      out_valid     <= r_v2;
      result        <= r_op2 ? w_fres32 : w_float;
      out_tag       <= r_tag2;
      flag_inexact  <= r_op2 ? r_ix2 : (!r_zero2 && (w_guard || w_sticky));
      flag_overflow <= r_op2 && r_ovf2;
      flag_invalid  <= r_op2 && r_nan2;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fixed_float_pipe.sv
// ============================================================================
//  Module      : tb_fixed_float_pipe
//  Description : Scoreboard bench for fixed_float_pipe with directed vectors.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fixed_float_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        opcode;
  logic [31:0] targetnumber;
  logic [4:0]  fixpointpos;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [3:0]  out_tag;
  logic        flag_inexact, flag_overflow, flag_invalid;

  fixed_float_pipe #(.FIX_W(32), .POS_W(5), .TAG_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .targetnumber(targetnumber), .fixpointpos(fixpointpos),
    .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .out_tag(out_tag), .flag_inexact(flag_inexact),
    .flag_overflow(flag_overflow), .flag_invalid(flag_invalid)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] res;
    logic [3:0]  tag;
    logic [2:0]  flg;   // {inexact, overflow, invalid}
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", nm, act, req);
    end
  endtask

  task automatic send(input logic op, input logic [31:0] num, input logic [4:0] pos,
                      input logic [3:0] tag, input logic [31:0] eres, input logic [2:0] eflg);
    bit acc = 1'b0;
    int n = 0;
    opcode = op; targetnumber = num; fixpointpos = pos; in_tag = tag; in_valid = 1'b1;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      n++;
    end
    if (acc) q.push_back('{eres, tag, eflg});
    else begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout tag=%0d: in_ready got 0 required 1", tag);
    end
    #1 in_valid = 1'b0;
  endtask

  // Counts edges after an accept until out_valid is seen.
  task automatic lat_check(input string nm);
    int lat = 0;
    while (lat < 20) begin
      @(posedge clk);
      #1 lat++;
      if (out_valid) break;
    end
    chk(nm, 32'(lat), 32'd3);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk("drain_queue_empty", 32'(q.size()), 32'd0);
  endtask

  // Monitor: compares every output handshake and checks stall stability.
  initial begin : monitor
    logic [38:0] held = '0;
    bit          stalled = 1'b0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        stalled = 1'b0;
      end else begin
        if (stalled && out_valid) begin
          n_cmp++;
          if ({result, out_tag, flag_inexact, flag_overflow, flag_invalid} !== held) begin
            n_bad++;
            $display("FAIL stall_stable: got %h required %h",
                     {result, out_tag, flag_inexact, flag_overflow, flag_invalid}, held);
          end
        end
        if (out_valid && !out_ready) begin
          n_cmp++;
          if (in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL in_ready_stall: got %b required 0", in_ready);
          end
        end
        stalled = out_valid && !out_ready;
        held    = {result, out_tag, flag_inexact, flag_overflow, flag_invalid};
        if (out_valid && out_ready) begin
          n_cmp++;
          if (q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_output: got tag %0d result %h required no output", out_tag, result);
          end else begin
            e = q.pop_front();
            if (result !== e.res || out_tag !== e.tag ||
                {flag_inexact, flag_overflow, flag_invalid} !== e.flg) begin
              n_bad++;
              $display("FAIL output tag %0d: got %h/%0d/%b required %h/%0d/%b",
                       e.tag, result, out_tag, {flag_inexact, flag_overflow, flag_invalid},
                       e.res, e.tag, e.flg);
            end
          end
        end
      end
    end
  end

  initial begin : stim
    int n;
    logic [31:0] bp_exp [1:6];
    bp_exp[1] = 32'h3F800000; bp_exp[2] = 32'h40000000; bp_exp[3] = 32'h40400000;
    bp_exp[4] = 32'h40800000; bp_exp[5] = 32'h40A00000; bp_exp[6] = 32'h40C00000;

    rst = 1'b0; in_valid = 1'b0; opcode = 1'b0; targetnumber = '0;
    fixpointpos = '0; in_tag = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_result", result, 32'd0);
    chk("reset_out_tag", 32'(out_tag), 32'd0);
    chk("reset_flags", 32'({flag_inexact, flag_overflow, flag_invalid}), 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("in_ready_after_reset", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    send(1'b0, 32'h00000065, 5'd2, 4'd1, 32'h41CA0000, 3'b000);
    lat_check("latency_first");
    send(1'b1, 32'h41CA0000, 5'd2,  4'd2,  32'h00000065, 3'b000);
    send(1'b1, 32'hC1CA0000, 5'd2,  4'd3,  32'hFFFFFF9B, 3'b000);
    send(1'b0, 32'hFFFFFF9B, 5'd2,  4'd4,  32'hC1CA0000, 3'b000);
    send(1'b0, 32'h01FFFFFF, 5'd0,  4'd5,  32'h4C000000, 3'b100);
    send(1'b1, 32'h3FC00000, 5'd0,  4'd6,  32'h00000001, 3'b100);
    send(1'b1, 32'h4F000000, 5'd0,  4'd7,  32'h7FFFFFFF, 3'b010);
    send(1'b1, 32'hCF000000, 5'd0,  4'd8,  32'h80000000, 3'b000);
    send(1'b1, 32'h7FC00000, 5'd0,  4'd9,  32'h00000000, 3'b001);
    send(1'b1, 32'h00000001, 5'd0,  4'd10, 32'h00000000, 3'b100);
    send(1'b0, 32'h00000000, 5'd5,  4'd11, 32'h00000000, 3'b000);
    send(1'b0, 32'h80000000, 5'd0,  4'd12, 32'hCF000000, 3'b000);
    send(1'b1, 32'h7F800000, 5'd0,  4'd13, 32'h7FFFFFFF, 3'b010);
    send(1'b1, 32'hFF800000, 5'd0,  4'd14, 32'h80000000, 3'b010);
    send(1'b1, 32'hCF000001, 5'd0,  4'd15, 32'h80000000, 3'b010);
    send(1'b0, 32'h40000000, 5'd31, 4'd0,  32'h3F000000, 3'b000);
    send(1'b1, 32'hBFC00000, 5'd0,  4'd1,  32'hFFFFFFFF, 3'b100);
    send(1'b0, 32'h01000001, 5'd0,  4'd2,  32'h4B800000, 3'b100);
    send(1'b0, 32'h01000003, 5'd0,  4'd3,  32'h4B800002, 3'b100);
    send(1'b1, 32'h3F000000, 5'd0,  4'd4,  32'h00000000, 3'b100);
    wait_drain();

    // Backpressure: six back-to-back conversions against a stalled sink.
    @(posedge clk); #1 out_ready = 1'b0;
    fork
      begin
        for (int k = 1; k <= 6; k++) send(1'b0, 32'(k), 5'd0, 4'(k), bp_exp[k], 3'b000);
      end
      begin
        n = 0;
        while (!out_valid && n < 20) begin @(posedge clk); #1 n++; end
        chk("bp_out_valid_rises", 32'(out_valid), 32'd1);
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    wait_drain();

    // Reset with three conversions in flight.
    @(posedge clk); #1 out_ready = 1'b0;
    send(1'b0, 32'h00000007, 5'd0, 4'd7, 32'h40E00000, 3'b000);
    send(1'b0, 32'h00000008, 5'd0, 4'd8, 32'h41000000, 3'b000);
    send(1'b0, 32'h00000009, 5'd0, 4'd9, 32'h41100000, 3'b000);
    n = 0;
    while (!out_valid && n < 20) begin @(posedge clk); #1 n++; end
    chk("pre_reset_out_valid", 32'(out_valid), 32'd1);
    #2 rst = 1'b0;
    #1 chk("reset_async_out_valid", 32'(out_valid), 32'd0);
    q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    chk("in_ready_after_midreset", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    send(1'b0, 32'h00000065, 5'd2, 4'd5, 32'h41CA0000, 3'b000);
    lat_check("latency_after_reset");
    wait_drain();

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
